// File: rtl/barrel_shifter16.sv
// Registered 16-bit barrel shifter: four cascaded log stages (1, 2, 4, 8)
// feeding a single output register. Modes: lsr, asr, lsl, ror.
module barrel_shifter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [3:0]  S,
  input  logic [1:0]  op,
  input  logic        in_valid,
  output logic [15:0] Y,
  output logic        out_valid
);

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_ASR = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // One mux stage. The arithmetic fill reads the stage input's MSB, which
  // earlier asr stages leave equal to A[15], so the cascade fills correctly.
  function automatic logic [15:0] shift_stage(input logic [15:0] d,
                                              input logic [1:0]  mode,
                                              input logic        en,
                                              input int unsigned sh);
    logic [15:0] r;
    r = d;
    if (en) begin
      case (mode)
        OP_LSR:  r = d >> sh;
        OP_ASR:  r = 16'($signed(d) >>> sh);
        OP_LSL:  r = d << sh;
        OP_ROR:  r = (d >> sh) | (d << (16 - sh));
        default: r = d;
      endcase
    end
    return r;
  endfunction

  logic [4:0][15:0] stg;
  assign stg[0] = A;

  for (genvar k = 0; k < 4; k++) begin : g_stage
    assign stg[k+1] = shift_stage(stg[k], op, S[k], 32'd1 << k);
  end

  logic [15:0] y_q, y_d;
  logic        out_valid_q, out_valid_d;

  // Y holds across idle cycles; out_valid only marks a freshly loaded result.
  always_comb begin
    y_d         = y_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      y_d         = stg[4];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q         <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shifter16.sv
// Bench for barrel_shifter16: arithmetic reference model checked every cycle,
// plus hand-computed directed vectors that pin the model.
module tb_barrel_shifter16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A;
  logic [3:0]  S;
  logic [1:0]  op;
  logic        in_valid;
  logic [15:0] Y;
  logic        out_valid;

  int errors = 0;
  int checks = 0;
  logic        chk_en = 1'b0;
  logic [15:0] exp_y  = 16'h0000;
  logic        exp_v  = 1'b0;
  logic [15:0] exp_q[$];

  barrel_shifter16 dut (
    .clk(clk), .rst_n(rst_n), .A(A), .S(S), .op(op),
    .in_valid(in_valid), .Y(Y), .out_valid(out_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_shift(input logic [15:0] a,
                                            input logic [3:0] s,
                                            input logic [1:0] m);
    logic [31:0] w;
    case (m)
      2'b00:   w = {16'h0000, a} >> s;
      2'b01:   w = {{16{a[15]}}, a} >> s;
      2'b10:   w = {16'h0000, a} << s;
      default: w = {a, a} >> s;
    endcase
    return w[15:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_y = 16'h0000;
      exp_v = 1'b0;
    end else if (in_valid) begin
      exp_y = ref_shift(A, S, op);
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_y", Y, exp_y);
      check("model_valid", {15'd0, out_valid}, {15'd0, exp_v});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] a, input logic [3:0] s,
                       input logic [1:0] m, input logic v);
    @(negedge clk);
    A = a; S = s; op = m; in_valid = v;
  endtask

  // Directed vector with a hand-computed result, checked one cycle later.
  task automatic pin(input string name, input logic [15:0] a, input logic [3:0] s,
                     input logic [1:0] m, input logic [15:0] lit);
    drive(a, s, m, 1'b1);
    exp_q.push_back(lit);
    @(posedge clk); #1;
    check({name, "_y"}, Y, exp_q.pop_front());
    check({name, "_valid"}, {15'd0, out_valid}, 16'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; A = 16'hDEAD; S = 4'd3; op = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_y", Y, 16'h0000);
    check("reset_valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    pin("zero",      16'd0,     4'd0,  2'b00, 16'd0);
    pin("lsr_16_2",  16'd16,    4'd2,  2'b00, 16'd4);
    pin("lsr_8000",  16'h8000,  4'd4,  2'b00, 16'h0800);
    pin("asr_8000",  16'h8000,  4'd4,  2'b01, 16'hF800);
    pin("asr_7fff",  16'h7FFF,  4'd15, 2'b01, 16'h0000);
    pin("lsl_0001",  16'h0001,  4'd15, 2'b10, 16'h8000);
    pin("lsl_8001",  16'h8001,  4'd1,  2'b10, 16'h0002);
    pin("ror_0001",  16'h0001,  4'd1,  2'b11, 16'h8000);
    pin("ror_1234",  16'h1234,  4'd4,  2'b11, 16'h4123);
    pin("asr_c003",  16'hC003,  4'd8,  2'b01, 16'hFFC0);
    for (int m = 0; m < 4; m++)
      pin("s0_ident", 16'hA5C3, 4'd0, 2'(m), 16'hA5C3);

    // Idle: inputs wiggle but are ignored, Y holds, out_valid drops.
    drive(16'hFFFF, 4'd7, 2'b10, 1'b0);
    @(posedge clk); #1;
    check("idle_hold_y", Y, 16'hA5C3);
    check("idle_valid", {15'd0, out_valid}, 16'd0);
    drive(16'h1234, 4'd1, 2'b11, 1'b0);

    // Eight back-to-back operations, op changing each cycle.
    for (int i = 0; i < 8; i++) begin
      drive(16'($urandom_range(0, 16'hFFFF)), 4'(i * 2 + 1), 2'(i), 1'b1);
      @(posedge clk); #1;
      check("b2b_valid", {15'd0, out_valid}, 16'd1);
    end

    // Sweep: every shift amount in every mode, random operand.
    for (int m = 0; m < 4; m++)
      for (int s = 0; s < 16; s++)
        drive(16'($urandom_range(0, 16'hFFFF)), 4'(s), 2'(m), 1'b1);

    // Reset in mid-stream with a valid operation pending.
    drive(16'hFFFF, 4'd1, 2'b10, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_y", Y, 16'h0000);
    check("midrst_valid", {15'd0, out_valid}, 16'd0);
    drive(16'h0F0F, 4'd2, 2'b00, 1'b0);
    rst_n = 1'b1;
    pin("post_rst",  16'h00F0,  4'd4,  2'b00, 16'h000F);

    drive(16'h0000, 4'd0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
